// File: rtl/status_register_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : status_register_if                                              |
// | Brief   : Load/select/flag bundle between decoder/ALU and status register |
// |           (save/restore only with STATUS_SHADOW_EN)                       |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
interface status_register_if #(
    parameter int NUM_STATUS_BITS = 3
);
    logic                       wr_en;
    logic                       sel_stat_in_alu_decoder;
    logic [NUM_STATUS_BITS-1:0] alu_status;
    logic [NUM_STATUS_BITS-1:0] dec_status;
    logic [NUM_STATUS_BITS-1:0] status;
`ifdef STATUS_SHADOW_EN
    logic                       save;
    logic                       restore;
`endif

    modport master (
        output wr_en,
        output sel_stat_in_alu_decoder,
        output alu_status,
        output dec_status,
`ifdef STATUS_SHADOW_EN
        output save,
        output restore,
`endif
        input  status
    );

    modport slave (
        input  wr_en,
        input  sel_stat_in_alu_decoder,
        input  alu_status,
        input  dec_status,
`ifdef STATUS_SHADOW_EN
        input  save,
        input  restore,
`endif
        output status
    );
endinterface
`default_nettype wire

// File: rtl/status_register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : status_register                                                 |
// | Brief   : CPU flag register loaded from ALU or decoder; optional shadow   |
// |           copy for interrupt entry/exit when STATUS_SHADOW_EN is defined  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module status_register #(
    parameter int NUM_STATUS_BITS = 3
) (
    input  wire logic          clk,
    input  wire logic          res_n,
    status_register_if.slave   bus
);

    logic [NUM_STATUS_BITS-1:0] r_status;
    logic [NUM_STATUS_BITS-1:0] w_status_next;

`ifdef STATUS_SHADOW_EN
    logic [NUM_STATUS_BITS-1:0] r_shadow;
`endif

    // Select is only consulted when loading, so an unknown source never leaks in.
    always_comb begin
        w_status_next = r_status;
        if (bus.wr_en) begin
            if (bus.sel_stat_in_alu_decoder) begin
                w_status_next = bus.alu_status;
            end else begin
                w_status_next = bus.dec_status;
            end
        end
`ifdef STATUS_SHADOW_EN
        if (bus.restore) begin
            w_status_next = r_shadow;
        end
`endif
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_status <= '0;
        end else begin
            r_status <= w_status_next;
        end
    end

`ifdef STATUS_SHADOW_EN
    // Shadow captures the pre-edge status, so save+restore together swaps.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_shadow <= '0;
        end else if (bus.save) begin
            r_shadow <= r_status;
        end
    end
`endif

    assign bus.status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_status_register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_status_register                                              |
// | Brief   : Scoreboard bench for status_register (STATUS_SHADOW_EN aware)   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_status_register;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic res_n = 1'b1;

    always #5 clk = ~clk;

    status_register_if #(.NUM_STATUS_BITS(N)) bus ();

    status_register #(.NUM_STATUS_BITS(N)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] m_status = '0;
    logic [N-1:0] m_shadow = '0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: status=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the flag vector after the next edge, advance.
    task automatic drive(input logic rn, input logic we, input logic sel,
                         input logic [N-1:0] alu, input logic [N-1:0] dec,
                         input logic sv, input logic rs);
        logic [N-1:0] nxt_status;
        logic [N-1:0] nxt_shadow;
        res_n                       = rn;
        bus.wr_en                   = we;
        bus.sel_stat_in_alu_decoder = sel;
        bus.alu_status              = alu;
        bus.dec_status              = dec;
`ifdef STATUS_SHADOW_EN
        bus.save                    = sv;
        bus.restore                 = rs;
`endif
        if (!rn) begin
            nxt_status = '0;
            nxt_shadow = '0;
        end else begin
            nxt_status = we ? (sel ? alu : dec) : m_status;
            nxt_shadow = m_shadow;
`ifdef STATUS_SHADOW_EN
            if (sv) nxt_shadow = m_status;
            if (rs) nxt_status = m_shadow;
`else
            if (sv || rs) nxt_shadow = m_shadow;
`endif
        end
        m_status = nxt_status;
        m_shadow = nxt_shadow;
        exp_q.push_back(nxt_status);
        @(negedge clk);
    endtask

    // Monitor: one expected value per edge, compared shortly after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                check("edge", bus.status, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: status=%b expected=drained", bus.status);
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_en                   = 1'b0;
        bus.sel_stat_in_alu_decoder = 1'b0;
        bus.alu_status              = '0;
        bus.dec_status              = '0;
`ifdef STATUS_SHADOW_EN
        bus.save                    = 1'b0;
        bus.restore                 = 1'b0;
`endif
        #1 res_n = 1'b0;
        #1 check("reset_async", bus.status, 3'b000);
        @(negedge clk);

        drive(0, 0, 0, 3'b000, 3'b000, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b000, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b000, 0, 0);
        // ALU path
        drive(1, 1, 1, 3'b001, 3'b011, 0, 0);
        drive(1, 1, 1, 3'b010, 3'b011, 0, 0);
        drive(1, 1, 1, 3'b000, 3'b011, 0, 0);
        // wr_en low holds
        drive(1, 0, 1, 3'b001, 3'b011, 0, 0);
        drive(1, 0, 1, 3'b001, 3'b110, 0, 0);
        // decoder path, unselected ALU ignored
        drive(1, 1, 0, 3'b001, 3'b011, 0, 0);
        drive(1, 1, 0, 3'b111, 3'b011, 0, 0);

        // Asynchronous reset between edges
        #2 res_n = 1'b0;
        #1 check("reset_mid_cycle", bus.status, 3'b000);
        m_status = '0;
        m_shadow = '0;
        @(negedge clk);
        drive(0, 1, 1, 3'b111, 3'b101, 0, 0);
        drive(0, 1, 0, 3'b111, 3'b101, 0, 0);
        drive(1, 0, 0, 3'b111, 3'b101, 0, 0);

`ifdef STATUS_SHADOW_EN
        drive(1, 1, 0, 3'b000, 3'b101, 0, 0);
        drive(1, 0, 0, 3'b000, 3'b000, 1, 0);
        drive(1, 1, 1, 3'b010, 3'b000, 0, 0);
        drive(1, 1, 1, 3'b111, 3'b000, 0, 1);
        drive(1, 1, 0, 3'b000, 3'b110, 0, 0);
        drive(1, 1, 0, 3'b000, 3'b011, 1, 1);
        drive(1, 0, 0, 3'b000, 3'b000, 0, 1);
`endif

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) != 0),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  N'($urandom), N'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        drive(1, 0, 0, 3'b000, 3'b000, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
